// File: rtl/rx_bps_ctrl.sv
// -----------------------------------------------------------------------------
// rx_bps_ctrl
// Bit-period timing controller for a UART-style receiver. Once a start bit
// has been detected, the block times each bit of the frame with a cycle
// counter. It raises a one-cycle strobe at the middle of every bit period,
// which is where the receiver samples the line.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_start    start-bit detected pulse (only honoured while idle)
//   rx_abort    cancel the frame in progress (highest priority while running)
//   div_val     clock cycles per bit, captured when a start is accepted
//   bps_clk     one-cycle mid-bit sample strobe
//   bit_idx     index of the bit being timed (0 = start bit)
//   busy        high while a frame is being timed
//   frame_done  one-cycle pulse after the last bit has been sampled
//   cfg_err     one-cycle pulse when a start is refused for a divisor below 4
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for rx_start; cnt and bit_idx held at 0
// S_RUN  | timing bits; cnt counts 0..div_q-1, bit_idx counts frame bits
// -----------------------------------------------------------------------------
module rx_bps_ctrl #(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_start,
    input  logic             rx_abort,
    input  logic [DIV_W-1:0] div_val,
    output logic             bps_clk,
    output logic [3:0]       bit_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    localparam int               FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam logic [3:0]       LAST_IDX   = 4'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_MIN    = DIV_W'(4);
    localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             frame_done_q, frame_done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             strobe;
    logic             wrap;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            bit_idx_q    <= bit_idx_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Output / decode logic. The strobe is masked by rx_abort so that an
    // abort never emits a sample in the cycle it takes effect.
    always_comb begin
        strobe     = (state_q == S_RUN) && (cnt_q == (div_q >> 1)) && !rx_abort;
        wrap       = (cnt_q == (div_q - ONE));
        bps_clk    = strobe;
        bit_idx    = bit_idx_q;
        busy       = (state_q == S_RUN);
        frame_done = frame_done_q;
        cfg_err    = cfg_err_q;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        bit_idx_d    = bit_idx_q;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_start) begin
                    if (div_val >= DIV_MIN) begin
                        state_d   = S_RUN;
                        div_d     = div_val;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (rx_abort) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else if (strobe && (bit_idx_q == LAST_IDX)) begin
                    // The frame ends at the last mid-bit sample; the remaining
                    // half of the stop bit is not timed so the next start can be
                    // accepted immediately.
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    bit_idx_d    = '0;
                    frame_done_d = 1'b1;
                end else if (wrap) begin
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rx_bps_ctrl.sv
module tb_rx_bps_ctrl;

    localparam int FB0 = 10;   // default configuration
    localparam int FB1 = 13;   // 9 data bits, parity, 2 stop bits

    localparam int K_STROBE = 0;
    localparam int K_DONE   = 1;
    localparam int K_CFGERR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_abort = 1'b0;
    logic [15:0] div_val = 16'd0;

    logic        bps0, busy0, fd0, ce0;
    logic [3:0]  idx0;
    logic        bps1, busy1, fd1, ce1;
    logic [3:0]  idx1;

    rx_bps_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_start(rx_start), .rx_abort(rx_abort),
        .div_val(div_val), .bps_clk(bps0), .bit_idx(idx0), .busy(busy0),
        .frame_done(fd0), .cfg_err(ce0)
    );

    rx_bps_ctrl #(.DIV_W(16), .DATA_BITS(9), .PARITY_EN(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_start(rx_start), .rx_abort(rx_abort),
        .div_val(div_val), .bps_clk(bps1), .bit_idx(idx1), .busy(busy1),
        .frame_done(fd1), .cfg_err(ce1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    // Reference model: a frame is described by the cycle in which its bit
    // timing starts and its divisor; every output event follows from that
    // by plain arithmetic.
    bit m_run[2];
    int m_t0[2];
    int m_div[2];
    bit exp_busy[2];
    int exp_idx[2];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void push_ev(int u, int kind, int c, int idx);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void flush_from(int c);
        while (q0.size() > 0 && q0[q0.size()-1].cyc >= c) q0.delete(q0.size()-1);
        while (q1.size() > 0 && q1[q1.size()-1].cyc >= c) q1.delete(q1.size()-1);
    endfunction

    function automatic void model_step(int u, int fb, bit s, bit a, int d, int c);
        int off, idx;
        exp_busy[u] = m_run[u];
        exp_idx[u]  = 0;
        if (m_run[u]) begin
            off = c - m_t0[u];
            idx = off / m_div[u];
            exp_idx[u] = idx;
            if (!a && (off % m_div[u]) == (m_div[u] / 2)) begin
                push_ev(u, K_STROBE, c, idx);
                if (idx == fb - 1) begin
                    m_run[u] = 1'b0;
                    push_ev(u, K_DONE, c + 1, 0);
                end
            end
            if (a) m_run[u] = 1'b0;
        end else if (s) begin
            if (d >= 4) begin
                m_run[u] = 1'b1;
                m_t0[u]  = c + 1;
                m_div[u] = d;
            end else begin
                push_ev(u, K_CFGERR, c + 1, 0);
            end
        end
    endfunction

    // Monitor: compares every presented output event against the scoreboard.
    function automatic void pop_cmp(int u, int kind, int idx);
        ev_t e;
        int  ok;
        string nm;
        nm = $sformatf("u%0d_ev_kind%0d", u, kind);
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            check({nm, "_unexpected"}, 1, 0);
            return;
        end
        e  = (u == 0) ? q0.pop_front() : q1.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc) && (kind != K_STROBE || e.idx == idx);
        if (!ok)
            $display("FAIL %s: got kind %0d cyc %0d idx %0d, expected kind %0d cyc %0d idx %0d",
                     nm, kind, cyc, idx, e.kind, e.cyc, e.idx);
        check(nm, ok, 1);
    endfunction

    function automatic void mon(int u, logic b, logic fd, logic ce, logic [3:0] idx, logic bsy);
        check($sformatf("u%0d_busy", u), int'(bsy), int'(exp_busy[u]));
        check($sformatf("u%0d_bit_idx", u), int'(idx), exp_idx[u]);
        if (b)  pop_cmp(u, K_STROBE, int'(idx));
        if (fd) pop_cmp(u, K_DONE, 0);
        if (ce) pop_cmp(u, K_CFGERR, 0);
    endfunction

    always @(negedge clk) begin
        mon(0, bps0, fd0, ce0, idx0, busy0);
        mon(1, bps1, fd1, ce1, idx1, busy1);
    end

    task automatic drive(bit s, bit a, int d);
        @(posedge clk);
        #1;
        rx_start = s;
        rx_abort = a;
        div_val  = 16'(d);
        if (rst_n) begin
            model_step(0, FB0, s, a, d, cyc);
            model_step(1, FB1, s, a, d, cyc);
        end
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_start = 1'b0;
        rx_abort = 1'b0;
        flush_from(cyc);
        for (int u = 0; u < 2; u++) begin
            m_run[u]    = 1'b0;
            exp_busy[u] = 1'b0;
            exp_idx[u]  = 0;
        end
        #1;
        check("rst_outputs_u0", int'({bps0, busy0, fd0, ce0, idx0}), 0);
        check("rst_outputs_u1", int'({bps1, busy1, fd1, ce1, idx1}), 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(int n, int d);
        repeat (n) drive(1'b0, 1'b0, d);
    endtask

    initial begin
        int d;
        bit s, a;
        for (int u = 0; u < 2; u++) begin
            m_run[u] = 1'b0; m_t0[u] = 0; m_div[u] = 4;
            exp_busy[u] = 1'b0; exp_idx[u] = 0;
        end

        do_reset(3);
        idle(3, 0);

        // Long frame at 434 cycles per bit; div_val wanders while running.
        drive(1'b1, 1'b0, 434);
        for (int i = 0; i < 5700; i++) drive(1'b0, 1'b0, $urandom_range(0, 600));
        idle(5, 434);

        // Refused start followed by the smallest legal divisor.
        drive(1'b1, 1'b0, 3);
        idle(4, 3);
        drive(1'b1, 1'b0, 4);
        idle(70, 4);

        // Abort mid-frame, then restart.
        drive(1'b1, 1'b0, 40);
        idle(130, 40);
        drive(1'b0, 1'b1, 40);
        idle(10, 40);
        drive(1'b1, 1'b1, 12);
        idle(200, 12);

        // Back-to-back frames with rx_start held high; divisor changes midway.
        for (int i = 0; i < 700; i++) drive(1'b1, 1'b0, (i < 350) ? 20 : 40);
        idle(600, 40);

        // Reset in the middle of a frame.
        drive(1'b1, 1'b0, 30);
        idle(130, 30);
        do_reset(3);
        idle(500, 30);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 4999) == 0) begin
                do_reset($urandom_range(1, 4));
            end else begin
                d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 24);
                s = ($urandom_range(0, 5) == 0);
                a = ($urandom_range(0, 399) == 0);
                drive(s, a, d);
            end
        end
        idle(400, 8);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
